bcd_scan_counter: RTL and testbench

- Four-decade BCD up/down counter (0000–9999) with a time-multiplexed digit scanner.
- Sits directly upstream of the BCD-to-seven-segment decoder.
- Presents one BCD digit at a time on digit_out, which drives the decoder's 4-bit input.
- Drives active-low digit enables (an) for a common-anode 4-digit display.

---
 rtl/bcd_scan_counter_pkg.sv | 18 +
 rtl/bcd_decade.sv | 40 ++++
 rtl/bcd_scan_counter.sv | 92 +++++++++
 tb/tb_bcd_scan_counter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_counter_pkg.sv
// rtl/bcd_scan_counter_pkg.sv - shared widths, constants and types for the BCD scan counter
package bcd_scan_counter_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int SCAN_CNT_W = 20;

    typedef logic [BCD_W-1:0] bcd_digit_t;

    localparam bcd_digit_t                BCD_MAX    = 4'd9;
    localparam logic [NUM_DIGITS-1:0]     AN_ALL_OFF = 4'b1111;

    // Active-low one-hot enable for the selected digit slot.
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// rtl/bcd_decade.sv - single-digit up/down BCD register with carry/borrow out
module bcd_decade
    import bcd_scan_counter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       step_in,
    input  logic       up,
    output bcd_digit_t value,
    output logic       step_out
);

    bcd_digit_t value_q;
    bcd_digit_t value_d;

    // Carry/borrow ripples combinationally so all decades settle in one cycle.
    assign step_out = step_in && (up ? (value_q == BCD_MAX) : (value_q == '0));
    assign value    = value_q;

    always_comb begin
        value_d = value_q;
        if (step_in) begin
            if (up) begin
                value_d = (value_q == BCD_MAX) ? '0 : value_q + 4'd1;
            end else begin
                value_d = (value_q == '0) ? BCD_MAX : value_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - four-decade BCD up/down counter with multiplexed digit scan
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  en,
    input  logic                  up,
    output logic [BCD_W-1:0]      digit_out,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  ovf
);

    localparam logic [SCAN_CNT_W-1:0] DIV_LAST = SCAN_CNT_W'(SCAN_DIV - 1);

    logic [NUM_DIGITS:0]     step;
    bcd_digit_t              digit [NUM_DIGITS];

    logic                    ovf_q;
    logic                    ovf_d;
    logic [SCAN_CNT_W-1:0]   div_q;
    logic [SCAN_CNT_W-1:0]   div_d;
    logic [1:0]              idx_q;
    logic [1:0]              idx_d;
    logic [NUM_DIGITS-1:0]   lz;
    logic                    zero_above;

    assign step[0] = en;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_decade
        bcd_decade u_decade (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .step_in  (step[g]),
            .up       (up),
            .value    (digit[g]),
            .step_out (step[g+1])
        );
    end

    // A step leaving the top decade is a full-range wrap in either direction.
    always_comb begin
        ovf_d = step[NUM_DIGITS] && !clear;
    end

    always_comb begin
        div_d = div_q + 20'd1;
        idx_d = idx_q;
        if (div_q >= DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            div_q <= '0;
            idx_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    // lz[i] is set when digit i and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (digit[i] == '0);
            lz[i]      = zero_above;
        end
    end

    always_comb begin
        digit_out = digit[idx_q];
        an        = an_select(idx_q);
        if ((BLANK_LZ != 0) && lz[idx_q]) begin
            an = AN_ALL_OFF;
        end
    end

    assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - randomized self-checking bench against an arithmetic reference model
module tb_bcd_scan_counter;

    logic       clk;
    logic       reset;
    logic       clear;
    logic       en;
    logic       up;
    logic [3:0] digit_out_a;
    logic [3:0] an_a;
    logic       ovf_a;
    logic [3:0] digit_out_b;
    logic [3:0] an_b;
    logic       ovf_b;

    localparam int DIV_A = 2;
    localparam int DIV_B = 3;

    bcd_scan_counter #(.SCAN_DIV(DIV_A), .BLANK_LZ(0)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (en),
        .up        (up),
        .digit_out (digit_out_a),
        .an        (an_a),
        .ovf       (ovf_a)
    );

    bcd_scan_counter #(.SCAN_DIV(DIV_B), .BLANK_LZ(1)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .en        (en),
        .up        (up),
        .digit_out (digit_out_b),
        .an        (an_b),
        .ovf       (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;
    int count;
    bit ovf_exp;
    int n_cyc;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (count=%0d cyc=%0d)", tag, obs, exp, count, n_cyc);
        end
    endtask

    function automatic int pow10(input int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        return p;
    endfunction

    function automatic int exp_idx(input int div);
        return (n_cyc / div) % 4;
    endfunction

    function automatic int exp_digit(input int div);
        return (count / pow10(exp_idx(div))) % 10;
    endfunction

    function automatic int exp_an(input int div, input bit blank);
        int k = exp_idx(div);
        if (blank && k > 0 && count < pow10(k)) return 15;
        return 15 - (1 << k);
    endfunction

    task automatic cycle(input bit r, input bit c, input bit e, input bit u);
        reset = r;
        clear = c;
        en    = e;
        up    = u;
        @(posedge clk);
        if (r) begin
            count   = 0;
            ovf_exp = 0;
            n_cyc   = 0;
        end else begin
            n_cyc++;
            ovf_exp = 0;
            if (c) begin
                count = 0;
            end else if (e) begin
                if (u) begin
                    if (count == 9999) begin count = 0; ovf_exp = 1; end
                    else count = count + 1;
                end else begin
                    if (count == 0) begin count = 9999; ovf_exp = 1; end
                    else count = count - 1;
                end
            end
        end
        #1;
        check_eq("ovf_a", int'(ovf_a), int'(ovf_exp));
        check_eq("ovf_b", int'(ovf_b), int'(ovf_exp));
        check_eq("digit_a", int'(digit_out_a), exp_digit(DIV_A));
        check_eq("an_a", int'(an_a), exp_an(DIV_A, 1'b0));
        check_eq("digit_b", int'(digit_out_b), exp_digit(DIV_B));
        check_eq("an_b", int'(an_b), exp_an(DIV_B, 1'b1));
    endtask

    task automatic run(input int n, input bit e, input bit u);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, e, u);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        count   = 0;
        ovf_exp = 0;
        n_cyc   = 0;

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("reset_an_a", int'(an_a), 14);
        check_eq("reset_digit_a", int'(digit_out_a), 0);

        run(4 * DIV_A, 1'b0, 1'b0);
        run(4 * DIV_B, 1'b0, 1'b0);

        run(10, 1'b1, 1'b1);
        check_eq("count10", count, 10);

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run(1, 1'b1, 1'b0);
        check_eq("dec_wrap_ovf", int'(ovf_a), 1);
        run(1, 1'b1, 1'b1);
        check_eq("inc_wrap_ovf", int'(ovf_a), 1);
        run(1, 1'b0, 1'b1);
        check_eq("ovf_one_cycle", int'(ovf_a), 0);

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run(10000, 1'b1, 1'b1);
        check_eq("full_lap", count, 0);

        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        run(42, 1'b1, 1'b1);
        run(4 * DIV_B, 1'b0, 1'b0);

        run(81, 1'b1, 1'b1);
        check_eq("count123", count, 123);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        check_eq("clear_ovf", int'(ovf_b), 0);
        run(2 * DIV_B, 1'b0, 1'b0);

        run(998, 1'b1, 1'b1);
        for (int i = 0; i < 12 && exp_idx(DIV_B) != 2; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("slot2_reached", exp_idx(DIV_B), 2);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("rst_an_b", int'(an_b), 14);
        check_eq("rst_digit_b", int'(digit_out_b), 0);
        run(5, 1'b1, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
